// File: rtl/sys_cmd_ctrl.sv
// Command sequencer: parses UART RX bytes into register-file write/read and ALU
// commands, then returns read data or the ALU result byte-wise to UART TX.
module sys_cmd_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_OUT_WIDTH = 16,
  parameter int FUN_WIDTH     = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  output logic [ADDR_WIDTH-1:0]    RF_ADDR,
  output logic                     RF_WR_EN,
  output logic [DATA_WIDTH-1:0]    RF_WR_DATA,
  output logic                     RF_RD_EN,
  input  logic [DATA_WIDTH-1:0]    RF_RD_DATA,
  input  logic                     RF_RD_VLD,
  output logic [FUN_WIDTH-1:0]     ALU_FUN,
  output logic                     ALU_EN,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  output logic                     CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  input  logic                     TX_BUSY,
  output logic [3:0]               state_dbg
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    ALU_A    = 4'd5,
    ALU_B    = 4'd6,
    ALU_FUNC = 4'd7,
    ALU_WAIT = 4'd8,
    TX_BYTE  = 4'd9,
    TX_GAP   = 4'd10
  } state_t;

  localparam logic [DATA_WIDTH-1:0] OP_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_NO = DATA_WIDTH'(8'hDD);

  state_t                   state_q, state_d;
  logic [ALU_OUT_WIDTH-1:0] payload_q, payload_d;
  logic [1:0]               left_q, left_d;

  logic [ADDR_WIDTH-1:0] rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_wr_data_d, tx_data_d;
  logic [FUN_WIDTH-1:0]  alu_fun_d;
  logic                  rf_wr_en_d, rf_rd_en_d, alu_en_d, cg_d, tx_vld_d;

  assign state_dbg = state_q;

  // Handshakes: RX_D_VLD, RF_RD_VLD and ALU_OUT_VLD are single-cycle strobes that
  // are only consumed in the state waiting for them; a byte goes to TX only when
  // TX_BUSY is sampled low, and TX_D_VLD is then high for exactly one cycle.
  always_comb begin
    state_d      = state_q;
    payload_d    = payload_q;
    left_d       = left_q;
    rf_addr_d    = RF_ADDR;
    rf_wr_data_d = RF_WR_DATA;
    alu_fun_d    = ALU_FUN;
    cg_d         = CLK_GATE_EN;
    tx_data_d    = TX_P_DATA;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    tx_vld_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            OP_WR:     state_d = WR_ADDR;
            OP_RD:     state_d = RD_ADDR;
            OP_ALU_OP: state_d = ALU_A;
            OP_ALU_NO: state_d = ALU_FUNC;
            default:   state_d = IDLE;
          endcase
        end
      end
      WR_ADDR: if (RX_D_VLD) begin
        rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d   = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        rf_wr_data_d = RX_P_DATA;
        rf_wr_en_d   = 1'b1;
        state_d      = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        rf_rd_en_d = 1'b1;
        state_d    = RD_WAIT;
      end
      RD_WAIT: if (RF_RD_VLD) begin
        payload_d = {{(ALU_OUT_WIDTH-DATA_WIDTH){1'b0}}, RF_RD_DATA};
        left_d    = 2'd1;
        state_d   = TX_BYTE;
      end
      ALU_A: if (RX_D_VLD) begin
        rf_addr_d    = '0;
        rf_wr_data_d = RX_P_DATA;
        rf_wr_en_d   = 1'b1;
        state_d      = ALU_B;
      end
      ALU_B: if (RX_D_VLD) begin
        rf_addr_d    = ADDR_WIDTH'(1);
        rf_wr_data_d = RX_P_DATA;
        rf_wr_en_d   = 1'b1;
        state_d      = ALU_FUNC;
      end
      ALU_FUNC: if (RX_D_VLD) begin
        alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
        alu_en_d  = 1'b1;
        cg_d      = 1'b1;
        state_d   = ALU_WAIT;
      end
      // The ALU clock stays enabled until its result has been captured.
      ALU_WAIT: if (ALU_OUT_VLD) begin
        payload_d = ALU_OUT;
        left_d    = 2'd2;
        cg_d      = 1'b0;
        state_d   = TX_BYTE;
      end
      TX_BYTE: if (!TX_BUSY) begin
        tx_data_d = payload_q[DATA_WIDTH-1:0];
        tx_vld_d  = 1'b1;
        payload_d = payload_q >> DATA_WIDTH;
        left_d    = left_q - 2'd1;
        state_d   = TX_GAP;
      end
      // One dead cycle lets the transmitter raise TX_BUSY before the next byte.
      TX_GAP:  state_d = (left_q != 2'd0) ? TX_BYTE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      payload_q   <= '0;
      left_q      <= '0;
      RF_ADDR     <= '0;
      RF_WR_EN    <= 1'b0;
      RF_WR_DATA  <= '0;
      RF_RD_EN    <= 1'b0;
      ALU_FUN     <= '0;
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
    end else begin
      state_q     <= state_d;
      payload_q   <= payload_d;
      left_q      <= left_d;
      RF_ADDR     <= rf_addr_d;
      RF_WR_EN    <= rf_wr_en_d;
      RF_WR_DATA  <= rf_wr_data_d;
      RF_RD_EN    <= rf_rd_en_d;
      ALU_FUN     <= alu_fun_d;
      ALU_EN      <= alu_en_d;
      CLK_GATE_EN <= cg_d;
      TX_P_DATA   <= tx_data_d;
      TX_D_VLD    <= tx_vld_d;
    end
  end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed bench for sys_cmd_ctrl with register-file, ALU and transmitter models.
module tb_sys_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [3:0]  RF_ADDR;
  logic        RF_WR_EN;
  logic [7:0]  RF_WR_DATA;
  logic        RF_RD_EN;
  logic [7:0]  RF_RD_DATA = 8'h00;
  logic        RF_RD_VLD = 1'b0;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT = 16'h0000;
  logic        ALU_OUT_VLD = 1'b0;
  logic        CLK_GATE_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_BUSY;
  logic [3:0]  state_dbg;

  sys_cmd_ctrl dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_WR_DATA(RF_WR_DATA),
    .RF_RD_EN(RF_RD_EN), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
    .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .CLK_GATE_EN(CLK_GATE_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_wr_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [3:0]  exp_rd_addr = 4'h0;
  logic [3:0]  exp_fun = 4'h0;
  logic [7:0]  rd_data = 8'h00;
  logic [15:0] alu_res = 16'h0000;
  bit          alu_resp_en = 1'b1;
  bit          busy_force = 1'b0;
  int          busy_cnt = 0;
  int          wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, tx_cnt = 0;
  int          kick_n = 0, kick_seen = 0;
  bit          prev_txv = 1'b0;
  logic        busy_at_edge = 1'b0;

  assign TX_BUSY = busy_force | (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(posedge CLK) busy_at_edge <= TX_BUSY;

  // Output monitor and transmitter model (busy for 10 cycles after each byte).
  always @(negedge CLK) begin
    if (RF_WR_EN) begin
      wr_cnt++;
      check("wr_unexpected", exp_wr_q.size() == 0, 0);
      if (exp_wr_q.size() != 0) check("wr_addr_data", {RF_ADDR, RF_WR_DATA}, exp_wr_q.pop_front());
    end
    if (RF_RD_EN) begin
      rd_cnt++;
      check("rd_addr", RF_ADDR, exp_rd_addr);
    end
    if (ALU_EN) begin
      alu_cnt++;
      check("alu_fun", ALU_FUN, exp_fun);
      check("cg_at_alu_en", CLK_GATE_EN, 1);
    end
    if (TX_D_VLD) begin
      tx_cnt++;
      check("tx_busy_respected", busy_at_edge, 0);
      check("tx_back_to_back", prev_txv, 0);
      check("tx_unexpected", exp_tx_q.size() == 0, 0);
      if (exp_tx_q.size() != 0) check("tx_byte", TX_P_DATA, exp_tx_q.pop_front());
      busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    prev_txv = TX_D_VLD;
  end

  // Register-file read model: data valid 3 cycles after the read strobe.
  always @(negedge CLK) begin
    if (RF_RD_EN) begin
      repeat (3) @(negedge CLK);
      RF_RD_DATA = rd_data;
      RF_RD_VLD  = 1'b1;
      @(negedge CLK);
      RF_RD_VLD  = 1'b0;
    end
  end

  // ALU model: result 5 cycles after ALU_EN; also a stray result on request.
  always @(negedge CLK) begin
    if (ALU_EN && alu_resp_en) begin
      repeat (5) @(negedge CLK);
      check("cg_during_wait", CLK_GATE_EN, 1);
      ALU_OUT     = alu_res;
      ALU_OUT_VLD = 1'b1;
      @(negedge CLK);
      ALU_OUT_VLD = 1'b0;
      check("cg_after_vld", CLK_GATE_EN, 0);
    end else if (kick_seen != kick_n) begin
      kick_seen   = kick_n;
      ALU_OUT     = 16'hBEEF;
      ALU_OUT_VLD = 1'b1;
      @(negedge CLK);
      ALU_OUT_VLD = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (state_dbg != 4'd0 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check(tag, state_dbg, 0);
  endtask

  // ---------------- stimulus ----------------
  int wr0, rd0, alu0, tx0;

  task automatic snap();
    wr0 = wr_cnt; rd0 = rd_cnt; alu0 = alu_cnt; tx0 = tx_cnt;
  endtask

  initial begin
    RST = 1'b0; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0;
    #2;
    check("rst_outputs", {RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_FUN, ALU_EN,
                          CLK_GATE_EN, TX_P_DATA, TX_D_VLD}, 0);
    check("rst_state", state_dbg, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // Write, then a back-to-back second write.
    snap();
    exp_wr_q.push_back({4'h5, 8'h7E});
    exp_wr_q.push_back({4'h6, 8'h11});
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h7E);
    send_byte(8'hAA); send_byte(8'h06); send_byte(8'h11);
    wait_idle("wr_idle");
    repeat (3) @(negedge CLK);
    check("wr_count", wr_cnt - wr0, 2);
    check("wr_no_tx", tx_cnt - tx0, 0);
    check("wr_addr_hold", RF_ADDR, 4'h6);
    check("wr_data_hold", RF_WR_DATA, 8'h11);

    // Read.
    snap();
    exp_rd_addr = 4'h3; rd_data = 8'h5A;
    exp_tx_q.push_back(8'h5A);
    send_byte(8'hBB); send_byte(8'h03);
    wait_idle("rd_idle");
    repeat (3) @(negedge CLK);
    check("rd_count", rd_cnt - rd0, 1);
    check("rd_tx_count", tx_cnt - tx0, 1);
    check("rd_tx_left", exp_tx_q.size(), 0);

    // ALU with operands.
    snap();
    exp_wr_q.push_back({4'h0, 8'hFF});
    exp_wr_q.push_back({4'h1, 8'h0F});
    exp_fun = 4'h1; alu_res = 16'h00F0;
    exp_tx_q.push_back(8'hF0);
    exp_tx_q.push_back(8'h00);
    send_byte(8'hCC); send_byte(8'hFF); send_byte(8'h0F); send_byte(8'h01);
    wait_idle("alu_op_idle");
    repeat (3) @(negedge CLK);
    check("alu_op_wr_count", wr_cnt - wr0, 2);
    check("alu_op_en_count", alu_cnt - alu0, 1);
    check("alu_op_tx_count", tx_cnt - tx0, 2);
    check("alu_op_cg_off", CLK_GATE_EN, 0);

    // ALU without operands, transmitter held busy.
    snap();
    busy_force = 1'b1;
    exp_fun = 4'h2; alu_res = 16'h1234;
    exp_tx_q.push_back(8'h34);
    exp_tx_q.push_back(8'h12);
    send_byte(8'hDD); send_byte(8'h02);
    repeat (50) @(negedge CLK);
    check("busy_no_tx", tx_cnt - tx0, 0);
    check("busy_state_tx_byte", state_dbg, 4'd9);
    busy_force = 1'b0;
    wait_idle("alu_no_idle");
    repeat (3) @(negedge CLK);
    check("alu_no_wr_count", wr_cnt - wr0, 0);
    check("alu_no_tx_count", tx_cnt - tx0, 2);
    check("alu_no_tx_left", exp_tx_q.size(), 0);

    // Robustness: unknown opcode, extra byte in RD_WAIT, then a write.
    snap();
    send_byte(8'h12);
    check("bad_opcode_idle", state_dbg, 0);
    exp_rd_addr = 4'h3; rd_data = 8'hC3;
    exp_tx_q.push_back(8'hC3);
    send_byte(8'hBB); send_byte(8'h03); send_byte(8'h44);
    check("rd_wait_hold", state_dbg, 4'd4);
    wait_idle("rob_rd_idle");
    exp_wr_q.push_back({4'h2, 8'h11});
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11);
    wait_idle("rob_wr_idle");
    repeat (3) @(negedge CLK);
    check("rob_wr_count", wr_cnt - wr0, 1);
    check("rob_rd_count", rd_cnt - rd0, 1);
    check("rob_tx_count", tx_cnt - tx0, 1);
    check("rob_wr_left", exp_wr_q.size(), 0);

    // Reset in ALU_WAIT, then a stray ALU result.
    repeat (12) @(negedge CLK);
    snap();
    alu_resp_en = 1'b0;
    exp_fun = 4'h2;
    send_byte(8'hDD); send_byte(8'h02);
    repeat (3) @(negedge CLK);
    check("pre_rst_state", state_dbg, 4'd8);
    check("pre_rst_cg", CLK_GATE_EN, 1);
    RST = 1'b0;
    #1;
    check("mid_rst_outputs", {RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_FUN, ALU_EN,
                              CLK_GATE_EN, TX_P_DATA, TX_D_VLD}, 0);
    check("mid_rst_state", state_dbg, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    kick_n++;
    repeat (20) @(negedge CLK);
    check("post_rst_no_tx", tx_cnt - tx0, 0);
    check("post_rst_state", state_dbg, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
